// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master split-capable bus arbiter.
package bus_arb_pkg;

  localparam int unsigned HOLD_CNT_W = 16;

  // Default maximum number of cycles a single grant may be held.
  localparam logic [HOLD_CNT_W-1:0] TIMEOUT_DEFAULT = 16'd1024;

  // bus_owner encodings, also used for last_owner and split_owner.
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M1   = 2'b01;
  localparam logic [1:0] OWNER_M2   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_RESUME = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_hold_timer.sv
// Grant hold counter: cleared while the bus is idle, counts while a grant is held,
// and flags (registered) when the count has reached LIMIT-1.
module arb_hold_timer
  import bus_arb_pkg::*;
#(
  parameter logic [HOLD_CNT_W-1:0] LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [HOLD_CNT_W-1:0] LAST = HOLD_CNT_W'(LIMIT - 16'd1);

  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  expired_q;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + HOLD_CNT_W'(1);
    end
  end

  // Count register; expired tracks the registered count so it needs no comparator on the output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= (LAST == '0);
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == LAST);
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/split_arbiter.sv
// Two-master round-robin bus arbiter with split-transaction support and a hold timeout.
// Split handling is compiled in only when ARB_SPLIT_EN is defined; otherwise s_split and
// s_split_resume are ignored and the split pulses stay low.
module split_arbiter
  import bus_arb_pkg::*;
#(
  parameter logic [HOLD_CNT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       s_ack,
  input  logic       s_split,
  input  logic       s_split_resume,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       m1_split_ack,
  output logic       m2_split_ack,
  output logic [1:0] bus_owner,
  output logic       timeout,
  output logic       split_err
);

`ifdef ARB_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  arb_state_e state_q;
  logic [1:0] bus_owner_q, last_owner_q, split_owner_q;
  logic       m1_grant_q, m2_grant_q;
  logic       m1_split_ack_q, m2_split_ack_q;
  logic       timeout_q, split_err_q;
  logic       split_pending_q, resume_latched_q;

  logic       hold_expired;
  logic       split_c, resume_go_c, m1_elig_c, m2_elig_c;
  logic [1:0] pick_c;

  arb_hold_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == ST_IDLE),
    .enable  (state_q != ST_IDLE),
    .expired (hold_expired)
  );

  // Request qualification and round-robin pick for the idle state.
  always_comb begin
    split_c     = SPLIT_EN && s_split;
    resume_go_c = SPLIT_EN && split_pending_q && (s_split_resume || resume_latched_q);
    m1_elig_c   = m1_req && !(split_pending_q && (split_owner_q == OWNER_M1));
    m2_elig_c   = m2_req && !(split_pending_q && (split_owner_q == OWNER_M2));
    pick_c      = OWNER_NONE;
    if (m1_elig_c && m2_elig_c) begin
      pick_c = (last_owner_q == OWNER_M1) ? OWNER_M2 : OWNER_M1;
    end else if (m1_elig_c) begin
      pick_c = OWNER_M1;
    end else if (m2_elig_c) begin
      pick_c = OWNER_M2;
    end
  end

  // Arbitration FSM with registered grants, owner and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      bus_owner_q      <= OWNER_NONE;
      last_owner_q     <= OWNER_M2;
      split_owner_q    <= OWNER_NONE;
      m1_grant_q       <= 1'b0;
      m2_grant_q       <= 1'b0;
      m1_split_ack_q   <= 1'b0;
      m2_split_ack_q   <= 1'b0;
      timeout_q        <= 1'b0;
      split_err_q      <= 1'b0;
      split_pending_q  <= 1'b0;
      resume_latched_q <= 1'b0;
    end else begin
      m1_split_ack_q <= 1'b0;
      m2_split_ack_q <= 1'b0;
      timeout_q      <= 1'b0;
      split_err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (resume_go_c) begin
            state_q     <= ST_RESUME;
            bus_owner_q <= split_owner_q;
            m1_grant_q  <= (split_owner_q == OWNER_M1);
            m2_grant_q  <= (split_owner_q == OWNER_M2);
          end else if (pick_c != OWNER_NONE) begin
            state_q     <= ST_OWNED;
            bus_owner_q <= pick_c;
            m1_grant_q  <= (pick_c == OWNER_M1);
            m2_grant_q  <= (pick_c == OWNER_M2);
          end
        end
        ST_OWNED: begin
          if (SPLIT_EN && split_pending_q && s_split_resume) begin
            resume_latched_q <= 1'b1;
          end
          if (s_ack || split_c || hold_expired) begin
            state_q      <= ST_IDLE;
            bus_owner_q  <= OWNER_NONE;
            m1_grant_q   <= 1'b0;
            m2_grant_q   <= 1'b0;
            last_owner_q <= bus_owner_q;
          end
          if (!s_ack && split_c) begin
            if (split_pending_q) begin
              split_err_q <= 1'b1;
            end else begin
              split_pending_q <= 1'b1;
              split_owner_q   <= bus_owner_q;
              m1_split_ack_q  <= (bus_owner_q == OWNER_M1);
              m2_split_ack_q  <= (bus_owner_q == OWNER_M2);
            end
          end else if (!s_ack && hold_expired) begin
            timeout_q <= 1'b1;
          end
        end
        ST_RESUME: begin
          if (s_ack || hold_expired) begin
            state_q          <= ST_IDLE;
            bus_owner_q      <= OWNER_NONE;
            m1_grant_q       <= 1'b0;
            m2_grant_q       <= 1'b0;
            last_owner_q     <= bus_owner_q;
            split_pending_q  <= 1'b0;
            resume_latched_q <= 1'b0;
            timeout_q        <= !s_ack;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          bus_owner_q <= OWNER_NONE;
          m1_grant_q  <= 1'b0;
          m2_grant_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m1_grant     = m1_grant_q;
  assign m2_grant     = m2_grant_q;
  assign m1_split_ack = m1_split_ack_q;
  assign m2_split_ack = m2_split_ack_q;
  assign bus_owner    = bus_owner_q;
  assign timeout      = timeout_q;
  assign split_err    = split_err_q;

endmodule

// File: tb/tb_split_arbiter.sv
// Bench for split_arbiter: directed scenarios followed by random traffic, all checked
// against a cycle-level behavioural model of who holds the bus and why.
module tb_split_arbiter;

  localparam logic [15:0] T_CYC = 16'd8;
  localparam int          T_INT = 8;

`ifdef ARB_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       m1_req, m2_req, s_ack, s_split, s_split_resume;
  logic       m1_grant, m2_grant, m1_split_ack, m2_split_ack, timeout, split_err;
  logic [1:0] bus_owner;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: owner 0 = nobody, 1 = master 1, 2 = master 2.
  int mo_owner, mo_last, mo_who, mo_held;
  bit mo_pend, mo_rflag, mo_resuming;
  bit e_sa1, e_sa2, e_to, e_err;

  split_arbiter #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m1_req         (m1_req),
    .m2_req         (m2_req),
    .s_ack          (s_ack),
    .s_split        (s_split),
    .s_split_resume (s_split_resume),
    .m1_grant       (m1_grant),
    .m2_grant       (m2_grant),
    .m1_split_ack   (m1_split_ack),
    .m2_split_ack   (m2_split_ack),
    .bus_owner      (bus_owner),
    .timeout        (timeout),
    .split_err      (split_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    mo_owner = 0; mo_last = 2; mo_who = 0; mo_held = 0;
    mo_pend = 0; mo_rflag = 0; mo_resuming = 0;
    e_sa1 = 0; e_sa2 = 0; e_to = 0; e_err = 0;
  endtask

  // One rising edge of the arbiter, described by bus ownership rules.
  task automatic model_step();
    bit e1, e2, done;
    e_sa1 = 0; e_sa2 = 0; e_to = 0; e_err = 0;
    if (mo_owner == 0) begin
      if (SPLIT_EN && mo_pend && (s_split_resume || mo_rflag)) begin
        mo_owner = mo_who; mo_resuming = 1; mo_held = 0;
      end else begin
        e1 = m1_req && !(mo_pend && mo_who == 1);
        e2 = m2_req && !(mo_pend && mo_who == 2);
        if (e1 && e2)  mo_owner = (mo_last == 1) ? 2 : 1;
        else if (e1)   mo_owner = 1;
        else if (e2)   mo_owner = 2;
        mo_held = 0; mo_resuming = 0;
      end
    end else begin
      done = 0;
      if (!mo_resuming && SPLIT_EN && mo_pend && s_split_resume) mo_rflag = 1;
      if (s_ack) begin
        done = 1;
        if (mo_resuming) begin mo_pend = 0; mo_rflag = 0; end
      end else if (!mo_resuming && SPLIT_EN && s_split) begin
        done = 1;
        if (mo_pend) e_err = 1;
        else begin
          mo_pend = 1; mo_who = mo_owner;
          e_sa1 = (mo_owner == 1); e_sa2 = (mo_owner == 2);
        end
      end else if (mo_held == T_INT - 1) begin
        done = 1; e_to = 1;
        if (mo_resuming) begin mo_pend = 0; mo_rflag = 0; end
      end else begin
        mo_held = mo_held + 1;
      end
      if (done) begin mo_last = mo_owner; mo_owner = 0; end
    end
  endtask

  task automatic check_all();
    logic [1:0] eo;
    eo = (mo_owner == 1) ? 2'b01 : (mo_owner == 2) ? 2'b10 : 2'b00;
    chk("m1_grant",     {1'b0, m1_grant},     {1'b0, mo_owner == 1});
    chk("m2_grant",     {1'b0, m2_grant},     {1'b0, mo_owner == 2});
    chk("bus_owner",    bus_owner,            eo);
    chk("m1_split_ack", {1'b0, m1_split_ack}, {1'b0, e_sa1});
    chk("m2_split_ack", {1'b0, m2_split_ack}, {1'b0, e_sa2});
    chk("timeout",      {1'b0, timeout},      {1'b0, e_to});
    chk("split_err",    {1'b0, split_err},    {1'b0, e_err});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m1_grant"},  {1'b0, m1_grant},  2'b00);
    chk({tag, "_m2_grant"},  {1'b0, m2_grant},  2'b00);
    chk({tag, "_bus_owner"}, bus_owner,         2'b00);
    chk({tag, "_split_ack"}, {m1_split_ack, m2_split_ack}, 2'b00);
    chk({tag, "_timeout"},   {1'b0, timeout},   2'b00);
    chk({tag, "_split_err"}, {1'b0, split_err}, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    m1_req = 0; m2_req = 0; s_ack = 0; s_split = 0; s_split_resume = 0;
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1'b1;

    // Simultaneous requests: master 1 wins the first tie, master 2 follows after s_ack.
    m1_req = 1; m2_req = 1;
    tick();
    chk("tie_m1_grant", {1'b0, m1_grant}, 2'b01);
    s_ack = 1;
    tick();
    s_ack = 0;
    tick();
    chk("rr_m2_grant", {1'b0, m2_grant}, 2'b01);
    s_ack = 1;
    tick();
    s_ack = 0; m1_req = 0; m2_req = 0;
    tick();

    // Master 1 alone, split on its third cycle.
    m1_req = 1;
    tick();
    tick();
    s_split = 1;
    tick();
    chk("split_ack_m1", {1'b0, m1_split_ack}, {1'b0, SPLIT_EN});
    chk("split_m1_grant", {1'b0, m1_grant}, {1'b0, !SPLIT_EN});
    s_split = 0; s_ack = 1; m1_req = 0;
    tick();
    chk("split_ack_pulse", {1'b0, m1_split_ack}, 2'b00);

    // Master 2 transaction with a resume arriving mid-flight; resume wins the next idle.
    s_ack = 0; m2_req = 1;
    tick();
    chk("m2_grant_during_split", {1'b0, m2_grant}, 2'b01);
    tick();
    s_split_resume = 1;
    tick();
    s_split_resume = 0; s_ack = 1;
    tick();
    s_ack = 0;
    tick();
    chk("resume_m1_grant", {1'b0, m1_grant}, {1'b0, SPLIT_EN});
    chk("resume_m2_grant", {1'b0, m2_grant}, {1'b0, !SPLIT_EN});
    tick();

    // Reset during the resumed transaction, then a fresh master 1 request.
    rst_n = 0;
    #1;
    check_zero("midreset");
    model_reset();
    m1_req = 1; m2_req = 0;
    #2;
    rst_n = 1;
    tick();
    chk("fresh_m1_grant", {1'b0, m1_grant}, 2'b01);

    // Split after reset must be accepted, not flagged as a second split.
    s_split = 1;
    tick();
    chk("post_reset_split_ack", {1'b0, m1_split_ack}, {1'b0, SPLIT_EN});
    chk("post_reset_no_err", {1'b0, split_err}, 2'b00);
    s_split = 0; m1_req = 0; s_ack = 1;
    tick();
    s_ack = 0; m2_req = 1;
    tick();
    s_split = 1;
    tick();
    chk("double_split_err", {1'b0, split_err}, {1'b0, SPLIT_EN});
    chk("double_split_m2_grant", {1'b0, m2_grant}, {1'b0, !SPLIT_EN});
    s_split = 0; m2_req = 0; s_ack = 1;
    tick();
    s_ack = 0; m2_req = 1;
    tick();

    // s_ack and s_split together behave as s_ack alone.
    s_ack = 1; s_split = 1;
    tick();
    chk("ack_split_release", {1'b0, m2_grant}, 2'b00);
    chk("ack_split_no_sack", {1'b0, m2_split_ack}, 2'b00);
    chk("ack_split_no_err", {1'b0, split_err}, 2'b00);
    s_ack = 0; s_split = 0; m2_req = 0;
    s_split_resume = 1;
    tick();
    s_split_resume = 0; s_ack = 1;
    tick();
    s_ack = 0;
    tick();

    // Hold timeout after TIMEOUT_CYCLES granted cycles.
    m2_req = 1;
    tick();
    chk("to_m2_grant", {1'b0, m2_grant}, 2'b01);
    for (int i = 1; i < T_INT; i++) begin
      tick();
      chk("to_hold_grant", {1'b0, m2_grant}, 2'b01);
      chk("to_hold_no_pulse", {1'b0, timeout}, 2'b00);
    end
    tick();
    chk("to_pulse", {1'b0, timeout}, 2'b01);
    chk("to_release", {1'b0, m2_grant}, 2'b00);
    m2_req = 0;
    tick();
    chk("to_pulse_end", {1'b0, timeout}, 2'b00);
    s_ack = 1;
    tick();
    s_ack = 0;

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 600; i++) begin
      m1_req         = ($urandom_range(0, 99) < 55);
      m2_req         = ($urandom_range(0, 99) < 55);
      s_ack          = ($urandom_range(0, 99) < 18);
      s_split        = ($urandom_range(0, 99) < 12);
      s_split_resume = ($urandom_range(0, 99) < 10);
      if (i == 300) begin
        rst_n = 0;
        #1;
        check_zero("rand_reset");
        model_reset();
        #2;
        rst_n = 1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/split_arbiter.md
SPLIT_ARBITER -- requirements
Module: split_arbiter

Interface
REQ-001 SHALL take parameter TIMEOUT_CYCLES, default 16'd1024, as the maximum cycles one grant is held without s_ack or s_split.
REQ-002 SHALL have clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have m1_req and m2_req, inputs, 1 bit each: bus requests from master 1 and master 2.
REQ-005 SHALL have s_ack, input, 1 bit: the slave has completed the current transaction.
REQ-006 SHALL have s_split, input, 1 bit: the slave splits the current transaction.
REQ-007 SHALL have s_split_resume, input, 1 bit: the split slave is ready to return data.
REQ-008 SHALL have m1_grant and m2_grant, outputs, 1 bit each, registered and one-hot-or-zero.
REQ-009 SHALL have m1_split_ack and m2_split_ack, outputs, 1 bit each: one-cycle split-accept pulses.
REQ-010 SHALL have bus_owner, output, 2 bits: 00 none, 01 master 1, 10 master 2; registered; drives the data-path mux select.
REQ-011 SHALL have timeout and split_err, outputs, 1 bit each: one-cycle pulses.

Function
REQ-012 SHALL implement the FSM states ST_IDLE, ST_OWNED and ST_RESUME.
REQ-013 In ST_IDLE with any eligible request, SHALL assert the chosen grant on the next cycle and move to ST_OWNED, giving 1-cycle req-to-grant latency.
REQ-014 SHALL arbitrate round-robin: when both masters request, grant the master not in last_owner; with a single requester, grant it.
REQ-015 A master with a pending split SHALL be ineligible for new grants until its split is resumed and completed.
REQ-016 In ST_OWNED, s_ack SHALL drop the grant next cycle, clear bus_owner, update last_owner and return to ST_IDLE, guaranteeing at least one ungranted cycle between owners.
REQ-017 In ST_OWNED with no pending split, s_split SHALL drop the grant, pulse the owner's split_ack in that same next cycle, record split_owner and set split_pending.
REQ-018 In ST_OWNED with split_pending already set, s_split SHALL pulse split_err and release the bus as if s_ack had occurred.
REQ-019 If s_ack and s_split are both asserted in one cycle, SHALL treat the cycle as s_ack and ignore s_split.
REQ-020 In ST_IDLE with split_pending and s_split_resume, SHALL grant split_owner regardless of its req, enter ST_RESUME, and take priority over all new requests.
REQ-021 If s_split_resume arrives while the bus is owned, SHALL latch it and serve it at the next ST_IDLE.
REQ-022 In ST_RESUME, s_ack SHALL release the bus, clear split_pending and the latched resume, and return to ST_IDLE.
REQ-023 The hold counter SHALL be 16 bits, clear on every grant, and increment each cycle in ST_OWNED or ST_RESUME.
REQ-024 When the hold counter reaches TIMEOUT_CYCLES-1 without s_ack or s_split, SHALL drop the grant, pulse timeout and go to ST_IDLE; split_pending SHALL be unchanged, except that a timeout in ST_RESUME clears it.
REQ-025 Deassertion of the owner's req while granted SHALL NOT release the bus; only s_ack, s_split or timeout release it.

Reset
REQ-026 While rst_n is low, SHALL force all grants, split_acks, timeout and split_err to 0 and bus_owner to 00.
REQ-027 While rst_n is low, SHALL force the state to ST_IDLE, clear split_pending, the latched resume and the counter, and set last_owner to master 2 so that master 1 wins the first tie.
REQ-028 Reset asserted mid-transaction SHALL abandon any pending split without a split_ack or error pulse.

Configuration
REQ-029 With ARB_SPLIT_EN defined, SHALL implement the split logic of REQ-015 to REQ-022.
REQ-030 Without ARB_SPLIT_EN, s_split and s_split_resume SHALL be ignored, split_ack and split_err SHALL be tied to 0, and ST_RESUME SHALL be unreachable.

Structure
REQ-031 The package bus_arb_pkg SHALL hold the state enum, the bus_owner encodings and the default TIMEOUT_CYCLES.
REQ-032 The hold counter SHALL be implemented as the sub-module arb_hold_timer (inputs clear and enable; output expired).

Verification
REQ-033 The bench SHALL drive m1_req and m2_req high in the same cycle after reset and check m1_grant=1 at cycle +1, and m2_grant=1 two cycles after s_ack.
REQ-034 The bench SHALL drive m1_req only, then s_split at cycle 3, and check m1_split_ack pulses for 1 cycle and m1_grant=0.
REQ-035 The bench SHALL then assert m2_req and check m2_grant; it SHALL assert s_split_resume during the master 2 transaction, apply s_ack, and check m1_grant before any new m2 grant.
REQ-036 The bench SHALL set TIMEOUT_CYCLES=8 and hold m2 granted without s_ack, and check that timeout pulses and m2_grant falls after 8 cycles.
REQ-037 The bench SHALL assert s_ack and s_split together and check release with no split_ack; it SHALL apply a second s_split while a split is pending and check split_err=1.
REQ-038 The bench SHALL drop rst_n during ST_RESUME and check all outputs are 0 and a fresh m1_req is granted without any stale resume.
